// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the FIFO write-side arbiter and its helpers.
package fifo_arb_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_t;

   localparam int STALL_W = 16;

   // Index width for n requesters; never below 1 so a 2-way arbiter still has a bit.
   function automatic int idx_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin search: first set req bit at or after ptr, wrapping mod N.
module rr_pick #(
   parameter int N  = 4,
   parameter int IW = 2
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic          valid,
   output logic [IW-1:0] idx
);

   logic [2*N-1:0] req2;
   logic [N-1:0]   rot;
   logic [IW:0]    sum;

   // Rotate so ptr lands at bit 0; scanning high-to-low leaves the lowest hit in idx.
   always_comb begin
      req2  = {req, req};
      rot   = req2[ptr +: N];
      valid = |req;
      idx   = '0;
      sum   = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (rot[i]) begin
            sum = {1'b0, ptr} + (IW + 1)'(i);
            idx = (sum >= (IW + 1)'(N)) ? IW'(sum - (IW + 1)'(N)) : IW'(sum);
         end
      end
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst-locking arbiter sharing one fifo_mem write port among N producers.
module fifo_wr_arbiter import fifo_arb_pkg::*; #(
   parameter  int N         = 4,
   parameter  int DW        = 8,
   parameter  int MAX_BURST = 4,
   localparam int IW        = idx_w(N)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N-1:0]       req_i,
   input  logic [N*DW-1:0]    data_i,
   output logic [N-1:0]       gnt_o,
   input  logic               fifo_full_i,
   output logic               fifo_wr_en_o,
   output logic [DW-1:0]      fifo_data_o,
   output logic               busy_o,
   output logic [IW-1:0]      owner_o,
   output logic [STALL_W-1:0] stall_cnt_o
);

   localparam int BW = $clog2(MAX_BURST + 1);

   arb_state_t         state, state_nx;
   logic [IW-1:0]      rr_ptr, rr_ptr_nx, owner, owner_nx;
   logic [IW-1:0]      pick_idx, sel_idx;
   logic [BW-1:0]      beat_cnt, beat_nx;
   logic               pick_vld, own_req, accept, last_beat;
   logic [STALL_W-1:0] stall_cnt;

   function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] i);
      return (i == IW'(N - 1)) ? '0 : i + 1'b1;
   endfunction

   rr_pick #(
      .N  (N),
      .IW (IW)
   ) u_pick (
      .req   (req_i),
      .ptr   (rr_ptr),
      .valid (pick_vld),
      .idx   (pick_idx)
   );

   // Grant is gated by rst so it drops immediately when reset asserts mid-burst.
   always_comb begin
      own_req     = req_i[owner];
      sel_idx     = (state == BUSY) ? owner : pick_idx;
      accept      = rst & ~fifo_full_i & ((state == BUSY) ? own_req : pick_vld);
      gnt_o       = accept ? (N'(1) << sel_idx) : '0;
      fifo_data_o = '0;
      for (int k = 0; k < N; k++) begin
         if (sel_idx == IW'(k)) fifo_data_o = data_i[k*DW +: DW];
      end
   end

   assign fifo_wr_en_o = |gnt_o;
   assign last_beat    = ((beat_cnt + 1'b1) == BW'(MAX_BURST));

   always_comb begin
      state_nx  = state;
      rr_ptr_nx = rr_ptr;
      owner_nx  = owner;
      beat_nx   = beat_cnt;
      case (state)
         IDLE: begin
            if (accept) begin
               if (MAX_BURST == 1) begin
                  rr_ptr_nx = wrap_inc(pick_idx);
               end else begin
                  owner_nx = pick_idx;
                  beat_nx  = BW'(1);
                  state_nx = BUSY;
               end
            end
         end
         BUSY: begin
            // Owner dropping its request releases the lock; full only pauses it.
            if (!own_req) begin
               state_nx  = IDLE;
               rr_ptr_nx = wrap_inc(owner);
            end else if (accept) begin
               beat_nx = beat_cnt + 1'b1;
               if (last_beat) begin
                  state_nx  = IDLE;
                  rr_ptr_nx = wrap_inc(owner);
               end
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         rr_ptr    <= '0;
         owner     <= '0;
         beat_cnt  <= '0;
         stall_cnt <= '0;
      end else begin
         state    <= state_nx;
         rr_ptr   <= rr_ptr_nx;
         owner    <= owner_nx;
         beat_cnt <= beat_nx;
         if ((|req_i) && fifo_full_i && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
      end
   end

   assign busy_o      = (state == BUSY);
   assign owner_o     = owner;
   assign stall_cnt_o = stall_cnt;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter with a small depth-8 FIFO model on the write port.
module tb_fifo_wr_arbiter;

   localparam int N  = 4;
   localparam int DW = 8;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    req_i;
   logic [N*DW-1:0] data_i;
   logic [N-1:0]    gnt_o;
   logic            fifo_full_i;
   logic            fifo_wr_en_o;
   logic [DW-1:0]   fifo_data_o;
   logic            busy_o;
   logic [1:0]      owner_o;
   logic [15:0]     stall_cnt_o;

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   fifo_wr_arbiter #(.N(N), .DW(DW), .MAX_BURST(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_i        (req_i),
      .data_i       (data_i),
      .gnt_o        (gnt_o),
      .fifo_full_i  (fifo_full_i),
      .fifo_wr_en_o (fifo_wr_en_o),
      .fifo_data_o  (fifo_data_o),
      .busy_o       (busy_o),
      .owner_o      (owner_o),
      .stall_cnt_o  (stall_cnt_o)
   );

   // Depth-8 FIFO model; tb_wr lets the bench prefill it while the arbiter is idle.
   logic [7:0] mem [8];
   logic [2:0] wp, rp;
   logic [3:0] cnt;
   logic       ovf, rd_en, tb_wr;
   logic [7:0] tb_wdata;
   wire        fwr   = fifo_wr_en_o | tb_wr;
   wire  [7:0] fwd   = fifo_wr_en_o ? fifo_data_o : tb_wdata;
   wire        do_rd = rd_en && (cnt != 4'd0);
   wire        do_wr = fwr && (cnt != 4'd8);
   assign fifo_full_i = (cnt == 4'd8);

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         wp  <= '0;
         rp  <= '0;
         cnt <= '0;
         ovf <= 1'b0;
      end else begin
         if (fwr && fifo_full_i) ovf <= 1'b1;
         if (do_wr) begin
            mem[wp] <= fwd;
            wp      <= wp + 1'b1;
         end
         if (do_rd) rp <= rp + 1'b1;
         cnt <= cnt + {3'b0, do_wr} - {3'b0, do_rd};
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_data(input int k, input logic [7:0] v);
      data_i[k*DW +: DW] = v;
   endtask

   task automatic drain();
      int b;
      b = 0;
      rd_en = 1'b1;
      while (cnt != 4'd0 && b < 20) begin
         tick();
         b++;
      end
      chk("drain_empty", cnt, 0);
      rd_en = 1'b0;
   endtask

   logic [7:0] exp3 [8];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      exp3 = '{8'hE2, 8'hE3, 8'hE4, 8'hE5, 8'hE6, 8'h31, 8'h32, 8'h33};
      rst = 1'b1; req_i = '1; data_i = '0; rd_en = 1'b0; tb_wr = 1'b0; tb_wdata = '0;
      #1 rst = 1'b0;

      // Reset with every requester asserted
      #9;
      chk("rst_gnt",   gnt_o, 0);
      chk("rst_wr_en", fifo_wr_en_o, 0);
      chk("rst_busy",  busy_o, 0);
      chk("rst_owner", owner_o, 0);
      chk("rst_stall", stall_cnt_o, 0);
      req_i = '0;
      @(negedge clk) rst = 1'b1;
      tick();

      // Single requester 1: two back-to-back bursts, re-grant straight from IDLE
      begin
         logic [7:0] v;
         v = 8'h00;
         for (int c = 0; c < 8; c++) begin
            req_i = 4'b0010;
            set_data(1, v);
            #1;
            chk("t1_gnt",  gnt_o, 4'b0010);
            chk("t1_busy", busy_o, (c % 4) != 0);
            chk("t1_data", fifo_data_o, v);
            if (gnt_o[1]) v = v + 1'b1;
            tick();
         end
      end
      req_i = '0;
      chk("t1_owner", owner_o, 1);
      chk("t1_level", cnt, 8);
      rd_en = 1'b1;
      for (int i = 0; i < 8; i++) begin
         #1 chk("t1_rd", mem[rp], i);
         tick();
      end
      rd_en = 1'b0;

      // Rotation from a fresh pointer: bursts 0,1,2,3,0
      rst = 1'b0; #1 rst = 1'b1;
      for (int k = 0; k < N; k++) set_data(k, 8'hA0 + 8'(k));
      req_i = 4'b1111;
      rd_en = 1'b1;
      for (int c = 0; c < 20; c++) begin
         int o;
         o = (c / 4) % 4;
         #1;
         chk("t2_gnt",  gnt_o, 1 << o);
         chk("t2_data", fifo_data_o, 8'hA0 + o);
         if (c % 4 != 0) chk("t2_owner", owner_o, o);
         tick();
      end
      req_i = '0;
      drain();

      // Full backpressure: prefill 7, one beat fits, then stall until reads free space
      tb_wr = 1'b1;
      for (int i = 0; i < 7; i++) begin
         tb_wdata = 8'hE0 + 8'(i);
         tick();
      end
      tb_wr = 1'b0;
      req_i = 4'b0001;
      set_data(0, 8'h31);
      #1;
      chk("t3_gnt_first", gnt_o, 4'b0001);
      chk("t3_data1", fifo_data_o, 8'h31);
      tick();
      set_data(0, 8'h32);
      for (int s = 0; s < 3; s++) begin
         #1;
         chk("t3_gnt_full", gnt_o, 0);
         chk("t3_wr_full",  fifo_wr_en_o, 0);
         chk("t3_busy_full", busy_o, 1);
         tick();
      end
      chk("t3_stall3", stall_cnt_o, 3);
      rd_en = 1'b1;
      #1 chk("t3_gnt_rd1", gnt_o, 0);
      tick();
      #1;
      chk("t3_gnt_beat2", gnt_o, 4'b0001);
      chk("t3_data2", fifo_data_o, 8'h32);
      tick();
      set_data(0, 8'h33);
      rd_en = 1'b0;
      #1;
      chk("t3_gnt_beat3", gnt_o, 4'b0001);
      chk("t3_data3", fifo_data_o, 8'h33);
      tick();
      req_i = '0;
      #1;
      chk("t3_release_gnt", gnt_o, 0);
      chk("t3_release_busy", busy_o, 1);
      tick();
      chk("t3_stall4", stall_cnt_o, 4);
      chk("t3_ovf", ovf, 0);
      chk("t3_idle", busy_o, 0);
      rd_en = 1'b1;
      for (int i = 0; i < 8; i++) begin
         #1 chk("t3_rd", mem[rp], exp3[i]);
         tick();
      end
      rd_en = 1'b0;
      chk("t3_empty", cnt, 0);

      // Early release: owner 2 drops after 2 beats, then 3 beats 0
      rd_en = 1'b1;
      set_data(2, 8'h42);
      set_data(3, 8'h43);
      req_i = 4'b1101;
      #1 chk("t4_gnt_b1", gnt_o, 4'b0100);
      tick();
      #1;
      chk("t4_gnt_b2", gnt_o, 4'b0100);
      chk("t4_owner2", owner_o, 2);
      tick();
      req_i = 4'b1001;
      #1;
      chk("t4_bubble_gnt", gnt_o, 0);
      chk("t4_bubble_busy", busy_o, 1);
      tick();
      #1;
      chk("t4_rr_gnt", gnt_o, 4'b1000);
      chk("t4_rr_data", fifo_data_o, 8'h43);
      chk("t4_rr_busy", busy_o, 0);
      tick();
      #1;
      chk("t4_owner3", owner_o, 3);
      chk("t4_gnt3", gnt_o, 4'b1000);
      tick();
      req_i = '0;
      tick();
      drain();

      // Mid-burst reset on owner 1
      req_i = 4'b0010;
      set_data(1, 8'h51);
      #1 chk("t5_gnt_b1", gnt_o, 4'b0010);
      tick();
      #1 chk("t5_gnt_b2", gnt_o, 4'b0010);
      rst = 1'b0;
      #1;
      chk("t5_rst_gnt",   gnt_o, 0);
      chk("t5_rst_wr",    fifo_wr_en_o, 0);
      chk("t5_rst_busy",  busy_o, 0);
      chk("t5_rst_owner", owner_o, 0);
      #1 rst = 1'b1;
      req_i = 4'b1111;
      #1;
      chk("t5_restart_gnt", gnt_o, 4'b0001);
      chk("t5_restart_busy", busy_o, 0);
      tick();
      chk("t5_owner0", owner_o, 0);
      chk("t5_busy", busy_o, 1);
      req_i = '0;
      tick();
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
